// File: rtl/led_timing_generator_pkg.sv
// led_timing_generator_pkg
//   Shared constants for the LED timing generator:
//   - UART receive state encoding (IDLE, ACTIVE)
//   - idx_width(): width of an index that counts 0..n-1, never narrower than 1 bit
package led_timing_generator_pkg;

  localparam logic [0:0] UART_IDLE   = 1'b0;
  localparam logic [0:0] UART_ACTIVE = 1'b1;

  // Index width for a modulo-n count: max(1, clog2(n)).
  function automatic int idx_width(input int n);
    return (n <= 32'sd2) ? 32'sd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_timing_generator_tick.sv
// tick_divider
//   Modulo-MODULUS counter used as one stage of the LED timing cascade.
//   Ports:
//     clock_i   system clock
//     reset_i   synchronous active-high reset, index returns to 0
//     step_i    advance the index by one (wraps MODULUS-1 -> 0)
//     carry_i   lookahead request; wrap_o answers "would this stage wrap?"
//     index_o   current index (registered)
//     wrap_o    carry_i while the index sits at MODULUS-1
//   The step and carry inputs are separate so the next stage's strobe can be
//   registered one cycle ahead of the index update it corresponds to.
module tick_divider #(
  parameter int MODULUS = 4,
  parameter int WIDTH   = 2
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             step_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] index_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] index_q;
  logic [WIDTH-1:0] index_d;

  // Next index: hold, wrap at the last value, or increment.
  always_comb begin
    index_d = index_q;
    if (!step_i) begin
      index_d = index_q;
    end else if (index_q == LAST) begin
      index_d = {WIDTH{1'b0}};
    end else begin
      index_d = index_q + WIDTH'(1);
    end
  end

  // Index register with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      index_q <= {WIDTH{1'b0}};
    end else begin
      index_q <= index_d;
    end
  end

  assign index_o = index_q;
  assign wrap_o  = carry_i && (index_q == LAST);

endmodule

// File: rtl/led_timing_generator.sv
// led_timing_generator
//   Clock-enable generator for the LED serialiser and UART receiver.
//   Ports:
//     clock, reset       system clock, synchronous active-high reset
//     enable             runs the LED timing chain (UART section unaffected)
//     uart_rx            asynchronous UART line, idle high
//     segment_tick, bit_tick, led_tick, frame_tick
//                        single-cycle strobes at the end of each period
//     segment_index, bit_index, led_index
//                        current position; each steps at the end of the
//                        cycle in which its strobe is high
//     baud_tick          strobe at the centre of each UART bit
//     uart_rx_sync       synchronised uart_rx
//     uart_active        high while a UART character is being timed
module led_timing_generator
  import led_timing_generator_pkg::*;
#(
  parameter int SEGMENT_DIVISOR  = 36,
  parameter int SEGMENTS_PER_BIT = 5,
  parameter int BITS_PER_LED     = 24,
  parameter int LEDS_PER_FRAME   = 60,
  parameter int BAUD_DIVISOR     = 1250,
  parameter int UART_BITS        = 10,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  enable,
  input  logic                                  uart_rx,
  output logic                                  segment_tick,
  output logic                                  bit_tick,
  output logic                                  led_tick,
  output logic                                  frame_tick,
  output logic [idx_width(SEGMENTS_PER_BIT)-1:0] segment_index,
  output logic [idx_width(BITS_PER_LED)-1:0]     bit_index,
  output logic [idx_width(LEDS_PER_FRAME)-1:0]   led_index,
  output logic                                  baud_tick,
  output logic                                  uart_rx_sync,
  output logic                                  uart_active
);

  localparam int DIV_W  = idx_width(SEGMENT_DIVISOR);
  localparam int SEG_W  = idx_width(SEGMENTS_PER_BIT);
  localparam int BIT_W  = idx_width(BITS_PER_LED);
  localparam int LED_W  = idx_width(LEDS_PER_FRAME);
  localparam int BAUD_W = idx_width(BAUD_DIVISOR);
  localparam int UBIT_W = idx_width(UART_BITS);

  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(BAUD_DIVISOR / 2 - 1);
  localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(BAUD_DIVISOR - 1);
  localparam logic [UBIT_W-1:0] UBIT_LAST = UBIT_W'(UART_BITS - 1);

  // ---------------- LED timing cascade ----------------
  // Each *_wrap_s is the lookahead for the strobe registered on the next edge.
  // The indices step on the registered strobe, so during a tick cycle the
  // index still shows the value the tick belongs to. A strobe already on the
  // output commits its index step even if enable drops in that same cycle.
  logic [DIV_W-1:0] div_count_unused_s;
  logic             seg_wrap_s;
  logic             bit_wrap_s;
  logic             led_wrap_s;
  logic             frame_wrap_s;
  logic             segment_tick_q;
  logic             bit_tick_q;
  logic             led_tick_q;
  logic             frame_tick_q;

  tick_divider #(.MODULUS(SEGMENT_DIVISOR), .WIDTH(DIV_W)) u_div (
    .clock_i(clock), .reset_i(reset), .step_i(enable), .carry_i(enable),
    .index_o(div_count_unused_s), .wrap_o(seg_wrap_s)
  );

  tick_divider #(.MODULUS(SEGMENTS_PER_BIT), .WIDTH(SEG_W)) u_seg (
    .clock_i(clock), .reset_i(reset), .step_i(segment_tick_q), .carry_i(seg_wrap_s),
    .index_o(segment_index), .wrap_o(bit_wrap_s)
  );

  tick_divider #(.MODULUS(BITS_PER_LED), .WIDTH(BIT_W)) u_bit (
    .clock_i(clock), .reset_i(reset), .step_i(bit_tick_q), .carry_i(bit_wrap_s),
    .index_o(bit_index), .wrap_o(led_wrap_s)
  );

  tick_divider #(.MODULUS(LEDS_PER_FRAME), .WIDTH(LED_W)) u_led (
    .clock_i(clock), .reset_i(reset), .step_i(led_tick_q), .carry_i(led_wrap_s),
    .index_o(led_index), .wrap_o(frame_wrap_s)
  );

  // Register the cascade strobes from their lookahead terms.
  always_ff @(posedge clock) begin
    if (reset) begin
      segment_tick_q <= 1'b0;
      bit_tick_q     <= 1'b0;
      led_tick_q     <= 1'b0;
      frame_tick_q   <= 1'b0;
    end else begin
      segment_tick_q <= seg_wrap_s;
      bit_tick_q     <= bit_wrap_s;
      led_tick_q     <= led_wrap_s;
      frame_tick_q   <= frame_wrap_s;
    end
  end

  assign segment_tick = segment_tick_q;
  assign bit_tick     = bit_tick_q;
  assign led_tick     = led_tick_q;
  assign frame_tick   = frame_tick_q;

  // ---------------- UART baud section ----------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   fall_s;
  logic [0:0]             uart_state_q, uart_state_d;
  logic [BAUD_W-1:0]      baud_cnt_q, baud_cnt_d;
  logic [UBIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                   baud_tick_q, baud_tick_d;

  // uart_rx synchroniser, idle-high after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
    end
  end

  // Falling edge seen one stage ahead of uart_rx_sync.
  assign fall_s = sync_q[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-2];

  // Baud state machine: half-period load to hit the start-bit centre, then
  // full periods; start edges during a character are ignored.
  always_comb begin
    uart_state_d = uart_state_q;
    baud_cnt_d   = baud_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    case (uart_state_q)
      UART_IDLE: begin
        if (fall_s) begin
          uart_state_d = UART_ACTIVE;
          baud_cnt_d   = BAUD_HALF;
          bit_cnt_d    = {UBIT_W{1'b0}};
        end else begin
          uart_state_d = UART_IDLE;
        end
      end
      UART_ACTIVE: begin
        if (baud_cnt_q == {BAUD_W{1'b0}}) begin
          baud_cnt_d = BAUD_FULL;
          if (bit_cnt_q == UBIT_LAST) begin
            uart_state_d = UART_IDLE;
            bit_cnt_d    = {UBIT_W{1'b0}};
          end else begin
            bit_cnt_d = bit_cnt_q + UBIT_W'(1);
          end
        end else begin
          baud_cnt_d = baud_cnt_q - BAUD_W'(1);
        end
      end
      default: begin
        uart_state_d = UART_IDLE;
        baud_cnt_d   = {BAUD_W{1'b0}};
        bit_cnt_d    = {UBIT_W{1'b0}};
      end
    endcase
    // Registered strobe: high while the counter sits at 0 in ACTIVE.
    baud_tick_d = (uart_state_d == UART_ACTIVE) && (baud_cnt_d == {BAUD_W{1'b0}});
  end

  // UART state, counters and baud strobe registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      uart_state_q <= UART_IDLE;
      baud_cnt_q   <= {BAUD_W{1'b0}};
      bit_cnt_q    <= {UBIT_W{1'b0}};
      baud_tick_q  <= 1'b0;
    end else begin
      uart_state_q <= uart_state_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      baud_tick_q  <= baud_tick_d;
    end
  end

  assign baud_tick    = baud_tick_q;
  assign uart_rx_sync = sync_q[SYNC_STAGES-1];
  assign uart_active  = (uart_state_q == UART_ACTIVE);

endmodule

// File: tb/tb_led_timing_generator.sv
// tb_led_timing_generator
//   Directed bench: a small-parameter instance checked cycle by cycle against
//   hand-derived expectations, plus a default-parameter instance for periods.
module tb_led_timing_generator;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Small-parameter DUT
  logic       reset, enable, uart_rx;
  logic       segment_tick, bit_tick, led_tick, frame_tick;
  logic [1:0] segment_index;
  logic [0:0] bit_index, led_index;
  logic       baud_tick, uart_rx_sync, uart_active;

  led_timing_generator #(
    .SEGMENT_DIVISOR(4), .SEGMENTS_PER_BIT(3), .BITS_PER_LED(2), .LEDS_PER_FRAME(2),
    .BAUD_DIVISOR(8), .UART_BITS(10), .SYNC_STAGES(2)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .uart_rx(uart_rx),
    .segment_tick(segment_tick), .bit_tick(bit_tick), .led_tick(led_tick),
    .frame_tick(frame_tick), .segment_index(segment_index), .bit_index(bit_index),
    .led_index(led_index), .baud_tick(baud_tick), .uart_rx_sync(uart_rx_sync),
    .uart_active(uart_active)
  );

  // Default-parameter DUT
  logic       d_reset, d_enable, d_rx;
  logic       d_seg_tick, d_bit_tick, d_led_tick, d_frame_tick;
  logic [2:0] d_seg_idx;
  logic [4:0] d_bit_idx;
  logic [5:0] d_led_idx;
  logic       d_baud, d_sync, d_active;

  led_timing_generator dut_dflt (
    .clock(clock), .reset(d_reset), .enable(d_enable), .uart_rx(d_rx),
    .segment_tick(d_seg_tick), .bit_tick(d_bit_tick), .led_tick(d_led_tick),
    .frame_tick(d_frame_tick), .segment_index(d_seg_idx), .bit_index(d_bit_idx),
    .led_index(d_led_idx), .baud_tick(d_baud), .uart_rx_sync(d_sync),
    .uart_active(d_active)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Chain expectation state: enabled cycles and segment ticks seen so far.
  int   m_en;
  int   m_ticks;
  logic m_prev_en;

  task automatic model_clear();
    m_en      = 0;
    m_ticks   = 0;
    m_prev_en = 1'b0;
  endtask

  // Called at a negedge: compare this cycle, then account for it.
  task automatic chain_cycle();
    logic es, eb, el, ef;
    int   n;
    n  = m_ticks;
    es = m_prev_en && (m_en > 0) && (m_en % 4 == 0);
    eb = es && (n % 3 == 2);
    el = eb && ((n / 3) % 2 == 1);
    ef = el && ((n / 6) % 2 == 1);
    check("chain", 32'({segment_tick, bit_tick, led_tick, frame_tick,
                        segment_index, bit_index, led_index}),
          32'({es, eb, el, ef, 2'(n % 3), 1'((n / 3) % 2), 1'((n / 6) % 2)}));
    if (es) m_ticks++;
    m_prev_en = enable;
    if (enable) m_en++;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chain_cycle();
    end
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    enable  = 1'b0;
    uart_rx = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_ticks", 32'({segment_tick, bit_tick, led_tick, frame_tick, baud_tick}), 32'd0);
    check("rst_idx", 32'({segment_index, bit_index, led_index}), 32'd0);
    check("rst_uart", 32'({uart_active, uart_rx_sync}), 32'b01);
    @(posedge clock);
    #1;
    reset  = 1'b0;
    enable = 1'b1;
    model_clear();
  endtask

  initial begin
    int   first, second;
    logic et, ea, es;

    d_reset  = 1'b1;
    d_enable = 1'b0;
    d_rx     = 1'b1;

    // Free-running cascade, then a 7-cycle enable drop mid-bit.
    apply_reset();
    run_cycles(62);
    @(posedge clock); #1; enable = 1'b0;
    run_cycles(7);
    @(posedge clock); #1; enable = 1'b1;
    run_cycles(40);

    // Two characters with a mid-character glitch on the first.
    for (int k = 0; k < 170; k++) begin
      @(posedge clock); #1;
      uart_rx = !((k < 8) || (k >= 30 && k < 32) || (k >= 80 && k < 88));
      @(negedge clock);
      et = 1'b0;
      ea = 1'b0;
      for (int s = 0; s <= 80; s += 80) begin
        if (k >= s + 5 && k <= s + 77 && ((k - s - 5) % 8 == 0)) et = 1'b1;
        if (k >= s + 2 && k <= s + 77) ea = 1'b1;
      end
      es = !((k >= 2 && k < 10) || (k >= 32 && k < 34) || (k >= 82 && k < 90));
      check("uart", 32'({baud_tick, uart_active, uart_rx_sync}), 32'({et, ea, es}));
    end

    // One-cycle reset mid-frame, with a start edge already in the synchroniser.
    apply_reset();
    run_cycles(30);
    check("pre_rst_led", 32'(led_index), 32'd1);
    @(posedge clock); #1; uart_rx = 1'b0;
    @(posedge clock); #1; reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0; uart_rx = 1'b1; model_clear();
    @(negedge clock);
    chain_cycle();
    check("post_rst_uart", 32'({baud_tick, uart_active, uart_rx_sync}), 32'b001);
    run_cycles(20);

    // Default parameters: segment period and baud timing.
    @(posedge clock); #1; d_reset = 1'b0; d_enable = 1'b1;
    first  = -1;
    second = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (d_seg_tick) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    check("dflt_seg_first", 32'(first), 32'd36);
    check("dflt_seg_period", 32'(second - first), 32'd36);

    first  = -1;
    second = -1;
    @(posedge clock); #1; d_rx = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (k > 0) begin
        @(posedge clock); #1;
        if (k == 10) d_rx = 1'b1;
      end
      @(negedge clock);
      if (d_baud) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    check("dflt_baud_first", 32'(first), 32'd626);
    check("dflt_baud_gap", 32'(second - first), 32'd1250);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
